dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
// - Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and off-chip data memory.
// - MEM-stage load/store hits complete the same cycle.
// - Misses stall the whole pipeline via cpu_stall_o until the line is written back (if dirty) and refilled.
// - Replaces the direct Data_Memory connection in CPU; the testbench counts miss stalls through cpu_stall_o.
// PARAMETERS
// - LINES      16   number of cache lines; power of 2
// - LINE_BITS  256  line width (32 B = 8 words)
// - ADDR_W     32   byte address width
// PORTS
// - clk_i          in   1    clock
// - rst_i          in   1    reset, asynchronous, active-high
// - cpu_req_i      in   1    MEM stage access valid (MemRead | MemWrite)
// - cpu_we_i       in   1    1 = store, 0 = load
// - cpu_addr_i     in   32   byte address, word aligned
// - cpu_data_i     in   32   store data
// - cpu_data_o     out  32   load data; valid when cpu_req_i & !cpu_stall_o
// - cpu_stall_o    out  1    holds PC/IFID/IDEX/EXMEM/MEMWB while high
// - mem_enable_o   out  1    memory request strobe
// - mem_write_o    out  1    1 = writeback, 0 = refill
// - mem_addr_o     out  32   line-aligned address (low 5 bits zero)
// - mem_data_o     out  256  writeback line
// - mem_data_i     in   256  refill line
// - mem_ack_i      in   1    one-cycle pulse, memory op complete; fixed latency set by memory model
// BEHAVIOUR
// - Address split: offset[4:0], word select [4:2], index [8:5], tag [31:9] (23 bits).
// - Line state: valid, dirty, tag.
// - Hit = valid & tag match; evaluated combinationally from cpu_addr_i.
// - Reset (async): FSM=IDLE; all valid/dirty = 0; all outputs 0. Data array is not cleared.
// - Reset mid-miss aborts the transaction; no line is written.
// - FSM states and transitions:
//   - IDLE: if cpu_req_i & hit:
//     - load returns word in same cycle, stall=0;
//     - store writes word and sets dirty at posedge.
//   - IDLE: if cpu_req_i & !hit: stall=1; go to WB if victim valid & dirty, else go to REFILL.
//   - WB: mem_enable_o=1, mem_write_o=1, addr={victim tag,index,5'b0}, data=victim line; hold until mem_ack_i, then go to REFILL.
//   - REFILL: mem_enable_o=1, mem_write_o=0, addr={cpu tag,index,5'b0}; on mem_ack_i write line, tag, valid=1, dirty=0, then go to DONE.
//   - DONE: one cycle; replays access as a hit (store merges word, sets dirty); stall=0; go to IDLE.
// - mem_enable_o is held high until ack. It drops for at least one cycle between WB and REFILL.
// - cpu_stall_o is high from the miss cycle through REFILL inclusive, and low in DONE.
// - Miss latency = 1 + (WB ? memlat+1 : 0) + memlat + 1 cycles.
// - cpu_addr_i/cpu_data_i are stable during stall, because the pipeline is frozen.
// - Controller does not re-latch address; the bench checks stability with an assertion.
// - cpu_req_i=0 in IDLE: no state change, stall=0.
// - mem_ack_i outside WB/REFILL is ignored.
// - Store and load to same line back-to-back both hit; no extra stall.
// STRUCTURE
// - Shared package dcache_pkg:
//   - TAG_W, IDX_W, OFF_W, LINE_BITS;
//   - state enum {IDLE, WB, REFILL, DONE};
//   - address field slicing constants.
// - Sub-module dcache_sram: LINES x (tag+valid+dirty) and LINES x 256-bit data.
//   - Async read, sync write, async reset of valid/dirty only.
// - Top contains FSM, hit logic, word merge/select, memory interface muxing.
// TESTING
// - Cold load 0x0000_0000, memory word0=5: REFILL pulse seen; cpu_data_o=5 in DONE; stall high memlat+1 cycles; then hit.
// - Store 0x0000_0004 <= 7, then load 0x4: both hit (no stall).
//   - Line dirty; memory is unchanged at 0x4.
// - Load 0x0000_0200 (same index 0, tag 1) after dirty line 0:
//   - WB at addr 0x0 carries word1=7;
//   - then REFILL at 0x200; cpu_data_o = mem[0x200].
// - Load to clean conflicting line: no WB phase (mem_write_o never 1); miss latency = memlat+2.
// - Assert rst_i during REFILL before ack: stall=0, mem_enable_o=0 immediately; next access to that line misses.
// - Idle with cpu_req_i=0 and spurious mem_ack_i pulse: no state change, outputs stay 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry, address slicing and FSM state type for the L1 data cache.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package dcache_pkg;

    localparam int LINES     = 16;
    localparam int LINE_BITS = 256;
    localparam int ADDR_W    = 32;
    localparam int WORD_W    = 32;

    localparam int OFF_W     = $clog2(LINE_BITS / 8);     // 5: byte offset inside a line
    localparam int IDX_W     = $clog2(LINES);             // 4: line index
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W;    // 23: remaining upper bits

    localparam int WSEL_LSB  = 2;                         // word select starts above the byte lanes
    localparam int WSEL_W    = OFF_W - WSEL_LSB;          // 3: eight words per line
    localparam int IDX_LSB   = OFF_W;
    localparam int TAG_LSB   = OFF_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Line-aligned memory address built from a tag and an index.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty store plus line data array for the direct-mapped cache.
// Latency: combinational read, write takes effect at the next clock edge.
// Backpressure: none; the controller sequences every write.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     idx,
    output logic [TAG_W-1:0]     rd_tag,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 meta_we,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic                 wr_valid,
    input  logic                 wr_dirty,
    input  logic                 line_we,
    input  logic [LINE_BITS-1:0] wr_line
);

    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINE_BITS-1:0] data_mem [LINES];
    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;

    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_line  = data_mem[idx];

    // Valid/dirty bits are the only state cleared by reset; that alone invalidates every line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we) begin
            valid_q[idx] <= wr_valid;
            dirty_q[idx] <= wr_dirty;
        end
    end

    // Tag and data arrays are plain storage; a write is suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (!rst && meta_we) begin
            tag_mem[idx] <= wr_tag;
        end
        if (!rst && line_we) begin
            data_mem[idx] <= wr_line;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache between MEM stage and data memory.
// Latency: hits complete in the request cycle; a miss takes memlat+2 cycles (+memlat+1 with writeback).
// Backpressure: cpu_stall_o freezes the pipeline from the miss cycle until the refill lands.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [WORD_W-1:0]    cpu_data_i,
    output logic [WORD_W-1:0]    cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    state_t state_q, state_d;
    logic   gap_q, gap_d;       // first REFILL cycle after a writeback keeps the strobe low

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [WSEL_W-1:0]    wsel;
    logic                 unused_addr_bits;

    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_valid;
    logic                 rd_dirty;
    logic [LINE_BITS-1:0] rd_line;
    logic                 meta_we;
    logic [TAG_W-1:0]     wr_tag;
    logic                 wr_valid;
    logic                 wr_dirty;
    logic                 line_we;
    logic [LINE_BITS-1:0] wr_line;

    logic                 hit;
    logic [WORD_W-1:0]    rd_word;
    logic [LINE_BITS-1:0] merged_line;

    assign idx              = cpu_addr_i[IDX_LSB +: IDX_W];
    assign tag              = cpu_addr_i[TAG_LSB +: TAG_W];
    assign wsel             = cpu_addr_i[WSEL_LSB +: WSEL_W];
    assign unused_addr_bits = ^cpu_addr_i[WSEL_LSB-1:0];

    dcache_sram u_sram (
        .clk      (clk_i),
        .rst      (rst_i),
        .idx      (idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_line  (rd_line),
        .meta_we  (meta_we),
        .wr_tag   (wr_tag),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .line_we  (line_we),
        .wr_line  (wr_line)
    );

    assign hit     = rd_valid && (rd_tag == tag);
    assign rd_word = rd_line[wsel*WORD_W +: WORD_W];

    // Current line with the store word dropped into its slot.
    always_comb begin
        merged_line = rd_line;
        merged_line[wsel*WORD_W +: WORD_W] = cpu_data_i;
    end

    // State register; reset abandons any in-flight memory transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Next state, CPU/memory outputs and array write controls; everything is forced low in reset.
    always_comb begin
        state_d      = state_q;
        gap_d        = 1'b0;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        meta_we      = 1'b0;
        line_we      = 1'b0;
        wr_tag       = rd_tag;
        wr_valid     = rd_valid;
        wr_dirty     = rd_dirty;
        wr_line      = rd_line;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (cpu_req_i) begin
                        if (hit) begin
                            cpu_data_o = rd_word;
                            if (cpu_we_i) begin
                                line_we  = 1'b1;
                                meta_we  = 1'b1;
                                wr_line  = merged_line;
                                wr_dirty = 1'b1;
                            end
                        end else begin
                            cpu_stall_o = 1'b1;
                            state_d     = (rd_valid && rd_dirty) ? WB : REFILL;
                        end
                    end
                end
                WB: begin
                    // Victim tag is still in the array until the refill overwrites it.
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = line_addr(rd_tag, idx);
                    mem_data_o   = rd_line;
                    if (mem_ack_i) begin
                        state_d = REFILL;
                        gap_d   = 1'b1;
                    end
                end
                REFILL: begin
                    cpu_stall_o = 1'b1;
                    mem_addr_o  = line_addr(tag, idx);
                    if (!gap_q) begin
                        mem_enable_o = 1'b1;
                        if (mem_ack_i) begin
                            line_we  = 1'b1;
                            meta_we  = 1'b1;
                            wr_line  = mem_data_i;
                            wr_tag   = tag;
                            wr_valid = 1'b1;
                            wr_dirty = 1'b0;
                            state_d  = DONE;
                        end
                    end
                end
                DONE: begin
                    // Replay the frozen access against the freshly filled line.
                    cpu_data_o = rd_word;
                    if (cpu_req_i && cpu_we_i) begin
                        line_we  = 1'b1;
                        meta_we  = 1'b1;
                        wr_line  = merged_line;
                        wr_dirty = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: architectural memory model plus cache-tag model.
// Latency: memory model acks on the MEMLAT-th consecutive enabled cycle.
// Backpressure: accesses are held while cpu_stall_o is high.
module tb_dcache_controller;

    localparam int MEMLAT = 4;
    localparam int BOUND  = 200;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         stall;
    logic         mem_en;
    logic         mem_wr;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         ack_mdl = 1'b0;
    logic         ack_spur = 1'b0;
    logic         mem_ack;

    assign mem_ack = ack_mdl | ack_spur;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cpu_req_i    (req),
        .cpu_we_i     (we),
        .cpu_addr_i   (addr),
        .cpu_data_i   (wdata),
        .cpu_data_o   (cpu_rdata),
        .cpu_stall_o  (stall),
        .mem_enable_o (mem_en),
        .mem_write_o  (mem_wr),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_wdata),
        .mem_data_i   (mem_rdata),
        .mem_ack_i    (mem_ack)
    );

    // Backing memory (8 KB of lines) and the CPU's architectural view of memory.
    logic [255:0] mem  [256];
    logic [255:0] view [256];
    // What the cache must be holding, per index.
    logic         mv [16];
    logic         md [16];
    logic [22:0]  mt [16];

    int           checks = 0;
    int           errors = 0;

    logic [31:0]  exp_rdata = '0;
    logic         exp_wb = 1'b0;
    logic [31:0]  exp_wb_addr = '0;
    logic [255:0] exp_wb_line = '0;
    logic [31:0]  exp_rf_addr = '0;
    int           wb_cyc = 0;
    int           rf_cyc = 0;
    logic [31:0]  wb_word1 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic chk_line(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Memory model: ack on the MEMLAT-th enabled cycle, performing the line read or write then.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ack_mdl) begin
                ack_mdl = 1'b0;
                cnt     = 0;
            end else if (mem_en && !rst) begin
                cnt++;
                if (cnt == MEMLAT) begin
                    ack_mdl = 1'b1;
                    if (mem_wr) mem[mem_addr[12:5]] = mem_wdata;
                    else        mem_rdata = mem[mem_addr[12:5]];
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Per-cycle compare against the model's expectations, sampled on the falling edge.
    initial begin
        logic        held;
        logic [31:0] held_addr;
        held = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req && !stall && !we) chk("load_data", cpu_rdata, exp_rdata);
                if (!req) begin
                    chk("idle_stall", 32'(stall), 32'd0);
                    chk("idle_enable", 32'(mem_en), 32'd0);
                end
                if (mem_en && mem_wr) begin
                    wb_cyc++;
                    wb_word1 = mem_wdata[63:32];
                    chk("wb_allowed", 32'(exp_wb), 32'd1);
                    chk("wb_addr", mem_addr, exp_wb_addr);
                    chk_line("wb_line", mem_wdata, exp_wb_line);
                end
                if (mem_en && !mem_wr) begin
                    rf_cyc++;
                    chk("rf_addr", mem_addr, exp_rf_addr);
                end
                if (stall) begin
                    if (held) chk("addr_stable", addr, held_addr);
                    held      = 1'b1;
                    held_addr = addr;
                end else begin
                    held = 1'b0;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        for (int l = 0; l < 256; l++) view[l] = mem[l];
    endtask

    // One CPU access held until the stall clears; checks stall length and memory traffic.
    task automatic access(input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_data,
                          output logic [31:0] got, output int stalls);
        logic [3:0]  idx;
        logic [22:0] tg;
        logic [7:0]  ln;
        logic [31:0] vaddr;
        logic        hit;
        logic        wb;
        int          exp_stalls;
        @(posedge clk);
        #1;
        idx   = a_addr[8:5];
        tg    = a_addr[31:9];
        ln    = a_addr[12:5];
        hit   = mv[idx] && (mt[idx] == tg);
        wb    = !hit && mv[idx] && md[idx];
        vaddr = {mt[idx], idx, 5'b0};
        exp_wb      = wb;
        exp_wb_addr = vaddr;
        exp_wb_line = view[vaddr[12:5]];
        exp_rf_addr = {a_addr[31:5], 5'b0};
        exp_rdata   = view[ln][32*int'(a_addr[4:2]) +: 32];
        exp_stalls  = hit ? 0 : (wb ? 2*MEMLAT + 2 : MEMLAT + 1);
        wb_cyc = 0;
        rf_cyc = 0;
        stalls = 0;
        req   = 1'b1;
        we    = a_we;
        addr  = a_addr;
        wdata = a_data;
        for (int i = 0; i < BOUND; i++) begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
        end
        got = cpu_rdata;
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("wb_cycles", 32'(wb_cyc), wb ? 32'(MEMLAT) : 32'd0);
        chk("refill_cycles", 32'(rf_cyc), hit ? 32'd0 : 32'(MEMLAT));
        if (!hit) begin
            mv[idx] = 1'b1;
            mt[idx] = tg;
            md[idx] = 1'b0;
        end
        if (a_we) begin
            view[ln][32*int'(a_addr[4:2]) +: 32] = a_data;
            md[idx] = 1'b1;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        int          st;
        for (int l = 0; l < 256; l++)
            for (int w = 0; w < 8; w++)
                mem[l][32*w +: 32] = 32'h1000 * l + w;
        mem[0][31:0] = 32'd5;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_enable", 32'(mem_en), 32'd0);
        chk("rst_write", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk_line("rst_mem_data", mem_wdata, 256'd0);
        chk("rst_cpu_data", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold load, then hit
        access(1'b0, 32'h0000_0000, 32'd0, got, st);
        chk("cold_load_value", got, 32'd5);
        chk("cold_load_stall", 32'(st), 32'd5);
        access(1'b0, 32'h0000_0000, 32'd0, got, st);
        chk("rehit_stall", 32'(st), 32'd0);

        // Store then load, back to back, both hits; memory untouched
        access(1'b1, 32'h0000_0004, 32'd7, got, st);
        chk("store_hit_stall", 32'(st), 32'd0);
        access(1'b0, 32'h0000_0004, 32'd0, got, st);
        chk("load_after_store", got, 32'd7);
        chk("load_after_store_stall", 32'(st), 32'd0);
        idle();
        chk("mem_unchanged", mem[0][63:32], 32'd1);

        // Conflict with dirty line 0 -> writeback then refill
        access(1'b0, 32'h0000_0200, 32'd0, got, st);
        chk("conflict_value", got, 32'h0001_0000);
        chk("conflict_stall", 32'(st), 32'd10);
        chk("wb_word1", wb_word1, 32'd7);
        chk("mem_after_wb", mem[0][63:32], 32'd7);

        // Conflict with a clean line -> no writeback
        access(1'b0, 32'h0000_0000, 32'd0, got, st);
        chk("clean_conflict_value", got, 32'd5);
        chk("clean_conflict_wb", 32'(wb_cyc), 32'd0);

        // Store miss allocates, then loads from the same line
        access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, got, st);
        access(1'b0, 32'h0000_0048, 32'd0, got, st);
        chk("store_miss_merge", got, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_004C, 32'd0, got, st);
        chk("neighbour_word", got, 32'h0000_2003);
        idle();

        // Reset in the middle of a refill
        @(posedge clk);
        #1;
        exp_wb      = 1'b0;
        exp_rf_addr = 32'h0000_0060;
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h0000_0060;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_enable", 32'(mem_en), 32'd0);
        req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        access(1'b0, 32'h0000_0060, 32'd0, got, st);
        chk("after_rst_value", got, 32'h0000_3000);
        chk("after_rst_miss", 32'(st), 32'd5);
        access(1'b0, 32'h0000_0048, 32'd0, got, st);
        chk("dirty_lost_on_rst", got, 32'h0000_2002);
        idle();

        // Spurious ack while idle
        @(posedge clk);
        #1;
        ack_spur = 1'b1;
        @(negedge clk);
        chk("spur_stall", 32'(stall), 32'd0);
        chk("spur_enable", 32'(mem_en), 32'd0);
        chk("spur_write", 32'(mem_wr), 32'd0);
        chk("spur_cpu_data", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        ack_spur = 1'b0;
        @(negedge clk);
        chk("spur_after_enable", 32'(mem_en), 32'd0);
        access(1'b0, 32'h0000_0060, 32'd0, got, st);
        chk("spur_keeps_line", 32'(st), 32'd0);
        chk("spur_keeps_value", got, 32'h0000_3000);
        idle();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
